cla_pipe_addacc: RTL and testbench
==================================

// Module: cla_pipe_addacc
// PURPOSE
//  Parametrised, segment-pipelined carry-lookahead adder/subtractor with an internal accumulator.
//  Successor to the single-stage registered 128-bit CLA wrapper used in the MAC datapath.
//  Adds/subtracts two WIDTH-bit operands or accumulates into acc_q, one SEG_W-bit segment per stage.
//  Ready/valid on both sides; sits between the partial-product reduction and the MAC result register.
// PARAMETERS
//  WIDTH  128  operand/result width; must be a multiple of SEG_W
//  SEG_W  32   bits resolved per pipeline stage; NSEG = WIDTH/SEG_W (localparam) = pipeline depth
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts beat this cycle (combinational)
//  op         in   2      0=ADD a+b, 1=SUB a-b, 2=ACC acc_q+a, 3=LOAD acc_q<=a (sum=a)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (ignored for ACC/LOAD)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of MSB (SUB: 1 = no borrow; LOAD: 0)
//  ovf        out  1      two's-complement signed overflow (LOAD: 0)
//  acc_q      out  WIDTH  current accumulator value
// BEHAVIOUR
//  - Reset (sync): all stage valids, out_valid, sum, cout, ovf, acc_q <= 0; in_ready = 0 while rst=1.
//  - adv = !out_valid || out_ready. All stages shift together when adv=1; otherwise the whole pipe holds.
//    Bubbles are not squeezed out.
//  - Accept = in_valid && in_ready. in_ready = !rst && adv && !(op in {ACC,LOAD} && acc_busy).
//  - acc_busy = any stage 1..NSEG-1 valid holding an ACC/LOAD op. ADD/SUB are never interlocked.
//  - Operand B is ~b with cin=1 for SUB and b with cin=0 for ADD. For ACC it is a with acc_q sampled at accept.
//  - Stage k (1..NSEG) holds sum segments 0..k-1, the carry into segment k, and the unresolved
//    upper operand bits plus op.
//  - Segment 0 resolves combinationally at the accept edge. Stage NSEG is the output register.
//  - Latency: a beat accepted at edge E is visible on sum/out_valid after edge E+NSEG-1.
//    NSEG=1 gives a plain registered adder.
//  - Throughput: 1 beat/cycle for ADD/SUB. Dependent ACC/LOAD ops: 1 per NSEG cycles.
//  - acc_q is written, for ACC/LOAD only, on the edge the result enters stage NSEG.
//    An ACC accepted in the following cycle sees the new value.
//  - ovf = (opA[MSB]==opB'[MSB]) && (sum[MSB]!=opA[MSB]), where opB' is the post-inversion operand.
//  - While out_valid && !out_ready: sum/cout/ovf/acc_q are stable, no beat is lost, and order is preserved.
//  - Accept and output handshake in the same cycle is legal. The pipe advances and the new beat enters stage 1.
//  - rst mid-operation: in-flight beats are discarded. There is no partial output and acc_q returns to 0.
// STRUCTURE
//  - cla_pkg: op encoding typedef/localparams (OP_ADD, OP_SUB, OP_ACC, OP_LOAD), default WIDTH/SEG_W.
//  - Sub-module cla_seg: combinational SEG_W-bit CLA with 4-bit group generate/propagate lookahead.
//    Ports: a, b, cin, s, cout, ovf.
//  - The top level instantiates NSEG cla_seg in a generate loop, plus skew registers, the valid chain,
//    the acc_busy interlock and the accumulator.
// TESTING (WIDTH=128, SEG_W=32, NSEG=4)
//  1. ADD a=2^128-1, b=1 accepted at edge 0.
//     -> out_valid after edge 3; sum=0, cout=1, ovf=0.
//  2. SUB a=5, b=7 -> sum=2^128-2, cout=0, ovf=0.
//     SUB a=0x8000..0, b=1 -> sum=0x7FFF..F, ovf=1.
//  3. LOAD 10, then ACC 20 and ACC 30 offered back-to-back.
//     -> in_ready low 3 cycles before each ACC; sums 10, 30, 60; acc_q=60.
//  4. Stream 8 ADDs with out_ready=0 for 4 cycles mid-stream.
//     -> in_ready=0 and sum held during the stall; all 8 results arrive in order.
//  5. rst=1 with 3 beats in flight -> after the edge: out_valid=0, acc_q=0, in_ready=1 once rst=0.
//  6. ADD a=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1
//     -> sum=0x0000_0001_0000_0000_0000_0000_0000_0000; checks the carry across every segment boundary.

Source files
------------

// File: rtl/cla_pipe_addacc_pkg.sv
// Shared types and defaults for the segment-pipelined CLA adder/accumulator.
package cla_pipe_addacc_pkg;

    localparam int unsigned DEF_WIDTH = 128;
    localparam int unsigned DEF_SEG_W = 32;
    localparam int unsigned GRP_W     = 4;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_ACC  = 2'd2,
        OP_LOAD = 2'd3
    } op_e;

    // Ops that read or write the accumulator and therefore must be serialised.
    function automatic logic is_acc_op(input op_e op);
        return (op == OP_ACC) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/cla_pipe_addacc_if.sv
// Operand/result ready-valid bus of the pipelined adder.
interface cla_pipe_addacc_if
    import cla_pipe_addacc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] acc_q;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, acc_q
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, sum, cout, ovf, acc_q
    );

endinterface

// File: rtl/cla_pipe_addacc_seg.sv
// Combinational SEG_W-bit carry-lookahead adder slice built from 4-bit groups.
module cla_seg
    import cla_pipe_addacc_pkg::*;
#(
    parameter int unsigned SEG_W = DEF_SEG_W
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NGRP = SEG_W / GRP_W;

    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Bit carries inside each group, group carry-out from group generate/propagate.
    always_comb begin
        logic [GRP_W-1:0] gg;
        logic [GRP_W-1:0] pp;
        logic             ci;
        gg   = '0;
        pp   = '0;
        ci   = 1'b0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(NGRP); i++) begin
            gg = g[i*GRP_W +: GRP_W];
            pp = p[i*GRP_W +: GRP_W];
            ci = c[i*GRP_W];
            c[i*GRP_W + 1] = gg[0] | (pp[0] & ci);
            c[i*GRP_W + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
            c[i*GRP_W + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                           | ((&pp[2:0]) & ci);
            c[i*GRP_W + 4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                           | ((&pp[3:1]) & gg[0]) | ((&pp) & ci);
        end
    end

    assign s    = p ^ c[SEG_W-1:0];
    assign cout = c[SEG_W];
    assign ovf  = (a[SEG_W-1] == b[SEG_W-1]) && (s[SEG_W-1] != a[SEG_W-1]);

endmodule

// File: rtl/cla_pipe_addacc.sv
// Segment-pipelined CLA add/sub with accumulator; one SEG_W slice resolved per stage.
module cla_pipe_addacc
    import cla_pipe_addacc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    cla_pipe_addacc_if.slave bus
);

    localparam int unsigned NSEG     = WIDTH / SEG_W;
    localparam int unsigned NP       = (NSEG > 1) ? NSEG - 1 : 1;
    localparam bit          HAS_PIPE = (NSEG > 1);

    // Handshake
    logic adv_c;
    logic acc_busy_c;
    logic in_ready_c;
    logic accept_c;

    // Operands after op decode (segment 0 input)
    logic [WIDTH-1:0] in_a_c;
    logic [WIDTH-1:0] in_b_c;
    logic             in_cin_c;

    // Skew registers: index i holds stage i+1
    logic             v_q  [NP];
    op_e              op_q [NP];
    logic [WIDTH-1:0] pa_q [NP];
    logic [WIDTH-1:0] pb_q [NP];
    logic [WIDTH-1:0] ps_q [NP];
    logic             pc_q [NP];

    // Per-segment adder wiring
    logic [SEG_W-1:0] seg_a  [NSEG];
    logic [SEG_W-1:0] seg_b  [NSEG];
    logic [SEG_W-1:0] seg_s  [NSEG];
    logic             seg_ci [NSEG];
    logic             seg_co [NSEG];
    logic             seg_ov [NSEG];

    // Beat about to enter the output stage
    logic             last_v_c;
    op_e              last_op_c;
    logic [WIDTH-1:0] last_s_c;

    // Output stage and accumulator
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic [WIDTH-1:0] acc_reg;

    assign adv_c      = !out_valid_q || bus.out_ready;
    assign in_ready_c = !rst && adv_c && !(is_acc_op(bus.op) && acc_busy_c);
    assign accept_c   = bus.in_valid && in_ready_c;

    // Any accumulator op still in flight blocks a new ACC/LOAD.
    always_comb begin
        acc_busy_c = 1'b0;
        for (int i = 0; i < int'(NP); i++) begin
            if (v_q[i] && is_acc_op(op_q[i])) begin
                acc_busy_c = 1'b1;
            end
        end
    end

    // Decode op into adder operands; ACC reads acc_reg at accept.
    always_comb begin
        in_a_c   = bus.a;
        in_b_c   = bus.b;
        in_cin_c = 1'b0;
        case (bus.op)
            OP_SUB: begin
                in_b_c   = ~bus.b;
                in_cin_c = 1'b1;
            end
            OP_ACC: begin
                in_a_c = acc_reg;
                in_b_c = bus.a;
            end
            OP_LOAD: in_b_c = '0;
            default: ;
        endcase
    end

    // One CLA slice per stage: slice 0 on the input, slice k on stage k's skewed operands.
    for (genvar k = 0; k < int'(NSEG); k++) begin : g_seg
        if (k == 0) begin : g_in
            assign seg_a[k]  = in_a_c[SEG_W-1:0];
            assign seg_b[k]  = in_b_c[SEG_W-1:0];
            assign seg_ci[k] = in_cin_c;
        end else begin : g_pipe
            assign seg_a[k]  = pa_q[k-1][k*SEG_W +: SEG_W];
            assign seg_b[k]  = pb_q[k-1][k*SEG_W +: SEG_W];
            assign seg_ci[k] = pc_q[k-1];
        end

        cla_seg #(.SEG_W(SEG_W)) u_seg (
            .a    (seg_a[k]),
            .b    (seg_b[k]),
            .cin  (seg_ci[k]),
            .s    (seg_s[k]),
            .cout (seg_co[k]),
            .ovf  (seg_ov[k])
        );
    end

    // Select the source feeding the output register.
    if (NSEG == 1) begin : g_last_in
        assign last_v_c  = accept_c;
        assign last_op_c = bus.op;
        assign last_s_c  = WIDTH'(seg_s[0]);
    end else begin : g_last_pipe
        assign last_v_c  = v_q[NP-1];
        assign last_op_c = op_q[NP-1];
        // Top segment completes the partial sum carried by the last skew stage.
        always_comb begin
            last_s_c = ps_q[NP-1];
            last_s_c[WIDTH-SEG_W +: SEG_W] = seg_s[NSEG-1];
        end
    end

    // Skew registers: whole pipe shifts on adv, bubbles are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NP); i++) begin
                v_q[i]  <= 1'b0;
                op_q[i] <= OP_ADD;
                pa_q[i] <= '0;
                pb_q[i] <= '0;
                ps_q[i] <= '0;
                pc_q[i] <= 1'b0;
            end
        end else if (adv_c) begin
            v_q[0]  <= HAS_PIPE && accept_c;
            op_q[0] <= bus.op;
            pa_q[0] <= in_a_c;
            pb_q[0] <= in_b_c;
            ps_q[0] <= WIDTH'(seg_s[0]);
            pc_q[0] <= seg_co[0];
            for (int i = 1; i < int'(NP); i++) begin
                v_q[i]  <= v_q[i-1];
                op_q[i] <= op_q[i-1];
                pa_q[i] <= pa_q[i-1];
                pb_q[i] <= pb_q[i-1];
                pc_q[i] <= seg_co[i];
                ps_q[i] <= ps_q[i-1];
                ps_q[i][i*SEG_W +: SEG_W] <= seg_s[i];
            end
        end
    end

    // Output stage; acc_reg captures ACC/LOAD results as they land here.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            acc_reg     <= '0;
        end else if (adv_c) begin
            out_valid_q <= last_v_c;
            if (last_v_c) begin
                sum_q  <= last_s_c;
                cout_q <= seg_co[NSEG-1];
                ovf_q  <= seg_ov[NSEG-1];
                if (is_acc_op(last_op_c)) begin
                    acc_reg <= last_s_c;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.acc_q     = acc_reg;

endmodule

// File: tb/tb_cla_pipe_addacc.sv
// Directed bench for cla_pipe_addacc (WIDTH=128, SEG_W=32).
module tb_cla_pipe_addacc;
    import cla_pipe_addacc_pkg::*;

    localparam int unsigned W  = 128;
    localparam int          NV = 12;

    typedef struct {
        op_e          op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cla_pipe_addacc_if #(.WIDTH(W)) bus ();

    cla_pipe_addacc #(.WIDTH(W), .SEG_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int           n_chk  = 0;
    int           n_pass = 0;
    logic         mon_en = 1'b0;
    logic [W-1:0] got_s[$];
    logic         got_c[$];
    vec_t         tv[NV];

    // Record every result beat taken by the consumer.
    always @(negedge clk) begin
        if (mon_en && !rst && bus.out_valid && bus.out_ready) begin
            got_s.push_back(bus.sum);
            got_c.push_back(bus.cout);
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_chk++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    // Offer one beat starting at posedge+1; returns with the beat accepted, at posedge+1.
    task automatic offer(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int stalls);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        stalls       = 0;
        #1;
        while (!bus.in_ready && stalls < 50) begin
            @(posedge clk); #2;
            stalls++;
        end
        if (stalls >= 50) timeout("offer");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 50) timeout("out_valid");
    endtask

    task automatic wait_q(input int n);
        int t = 0;
        while (got_s.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("result count", W'(got_s.size()), W'(n));
    endtask

    // Eight ADDs with a four-cycle downstream stall in the middle.
    task automatic stall_stream();
        logic [W-1:0] exp8[8];
        int st;
        for (int i = 0; i < 8; i++) exp8[i] = (W'(i + 1) << 64) | W'(i);
        got_s.delete();
        got_c.delete();
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    offer(OP_ADD, (W'(i) << 64) | W'(64'hFFFF_FFFF_FFFF_FFFF), W'(i + 1), st);
            end
            begin
                int n = 0;
                int hold;
                while (!bus.out_valid && n < 50) begin
                    @(posedge clk); #1;
                    n++;
                end
                if (n >= 50) timeout("stream first out");
                @(posedge clk); #1;
                bus.out_ready = 1'b0;
                hold = got_s.size();
                for (int c = 0; c < 4; c++) begin
                    #1;
                    chk($sformatf("stall%0d in_ready", c), W'(bus.in_ready), W'(0));
                    chk($sformatf("stall%0d out_valid", c), W'(bus.out_valid), W'(1));
                    chk($sformatf("stall%0d sum held", c), bus.sum, exp8[hold]);
                    @(posedge clk); #1;
                end
                chk("stall no beat taken", W'(got_s.size()), W'(hold));
                bus.out_ready = 1'b1;
            end
        join
        wait_q(8);
        for (int i = 0; i < 8 && i < got_s.size(); i++)
            chk($sformatf("stream%0d sum", i), got_s[i], exp8[i]);
        mon_en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int           st;
        int           lat;
        int           ghosts;
        logic [W-1:0] exp_acc;

        tv[0]  = '{OP_ADD,  {W{1'b1}}, W'(1), W'(0), 1'b1, 1'b0};
        tv[1]  = '{OP_SUB,  W'(5), W'(7),
                   128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0, 1'b0};
        tv[2]  = '{OP_SUB,  128'h80000000_00000000_00000000_00000000, W'(1),
                   128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1, 1'b1};
        tv[3]  = '{OP_ADD,  128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, W'(1),
                   128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0};
        tv[4]  = '{OP_ADD,  128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, W'(1),
                   128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1};
        tv[5]  = '{OP_ADD,  W'(3), W'(4), W'(7), 1'b0, 1'b0};
        tv[6]  = '{OP_SUB,  W'(7), W'(7), W'(0), 1'b1, 1'b0};
        tv[7]  = '{OP_ADD,  128'h80000000_00000000_00000000_00000000,
                   128'h80000000_00000000_00000000_00000000, W'(0), 1'b1, 1'b1};
        tv[8]  = '{OP_ADD,  W'(32'hFFFF_FFFF), W'(1), W'(36'h1_0000_0000), 1'b0, 1'b0};
        tv[9]  = '{OP_LOAD, 128'h80000000_DEADBEEF_01234567_89ABCDEF, {W{1'b1}},
                   128'h80000000_DEADBEEF_01234567_89ABCDEF, 1'b0, 1'b0};
        tv[10] = '{OP_SUB,  W'(0), 128'h80000000_00000000_00000000_00000000,
                   128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1};
        tv[11] = '{OP_ADD,  128'h12345678_9ABCDEF0_0FEDCBA9_87654321,
                   128'h11111111_11111111_11111111_11111111,
                   128'h23456789_ABCDF001_20FEDCBA_98765432, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.op        = OP_ADD;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        exp_acc       = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", W'(bus.in_ready), W'(0));
        chk("rst out_valid", W'(bus.out_valid), W'(0));
        chk("rst sum", bus.sum, W'(0));
        chk("rst cout", W'(bus.cout), W'(0));
        chk("rst ovf", W'(bus.ovf), W'(0));
        chk("rst acc_q", bus.acc_q, W'(0));
        rst = 1'b0;

        // Single-beat vectors
        for (int i = 0; i < NV; i++) begin
            offer(tv[i].op, tv[i].a, tv[i].b, st);
            chk($sformatf("vec%0d stalls", i), W'(st), W'(0));
            wait_out(lat);
            if (tv[i].op == OP_LOAD) exp_acc = tv[i].sum;
            chk($sformatf("vec%0d latency", i), W'(lat), W'(3));
            chk($sformatf("vec%0d sum", i), bus.sum, tv[i].sum);
            chk($sformatf("vec%0d cout", i), W'(bus.cout), W'(tv[i].cout));
            chk($sformatf("vec%0d ovf", i), W'(bus.ovf), W'(tv[i].ovf));
            chk($sformatf("vec%0d acc_q", i), bus.acc_q, exp_acc);
            @(posedge clk); #1;
        end

        // LOAD then two dependent ACCs offered back to back
        got_s.delete();
        got_c.delete();
        mon_en = 1'b1;
        offer(OP_LOAD, W'(10), W'(0), st);
        chk("load stalls", W'(st), W'(0));
        offer(OP_ACC, W'(20), W'(99), st);
        chk("acc20 stalls", W'(st), W'(3));
        offer(OP_ACC, W'(30), W'(0), st);
        chk("acc30 stalls", W'(st), W'(3));
        wait_q(3);
        if (got_s.size() >= 3) begin
            chk("acc seq sum0", got_s[0], W'(10));
            chk("acc seq sum1", got_s[1], W'(30));
            chk("acc seq sum2", got_s[2], W'(60));
            chk("acc seq cout2", W'(got_c[2]), W'(0));
        end
        chk("acc seq acc_q", bus.acc_q, W'(60));
        mon_en = 1'b0;
        @(posedge clk); #1;

        stall_stream();

        // Reset with three beats in flight
        offer(OP_ADD, W'(1), W'(2), st);
        offer(OP_ADD, W'(3), W'(4), st);
        offer(OP_ADD, W'(5), W'(6), st);
        rst = 1'b1;
        #1;
        chk("midrst in_ready", W'(bus.in_ready), W'(0));
        @(posedge clk); #1;
        chk("midrst out_valid", W'(bus.out_valid), W'(0));
        chk("midrst acc_q", bus.acc_q, W'(0));
        chk("midrst sum", bus.sum, W'(0));
        rst = 1'b0;
        #1;
        chk("postrst in_ready", W'(bus.in_ready), W'(1));
        ghosts = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) ghosts++;
        end
        chk("postrst no output", W'(ghosts), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Guard against a hung handshake.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
